// File: rtl/tpu_buf_pkg.sv
// Shared definitions for the TPU buffer responder: default geometry, host FSM
// state encoding and the wait-counter width.
package tpu_buf_pkg;

  localparam int unsigned DefWordWidth = 160;
  localparam int unsigned DefAddrWidth = 12;
  localparam int unsigned DefDepth     = 4096;
  localparam int unsigned WaitCntWidth = 16;

  typedef enum logic [1:0] {
    HIdle = 2'd0,
    HPend = 2'd1,
    HResp = 2'd2
  } host_state_e;

  // Index width for a RAM of the given depth (at least one bit).
  function automatic int unsigned ram_addr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tpu_buffer_responder_if.sv
// Bus bundle for tpu_buffer_responder: TPU buffer port plus host request/ack
// port. With TPU_BUF_WAIT_CNT_EN defined the bundle also carries host_wait_o.
interface tpu_buffer_responder_if
  import tpu_buf_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DefWordWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
);

  // TPU side
  logic                  en_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [WORD_WIDTH-1:0] word_i;
  logic [WORD_WIDTH-1:0] word_o;

  // Host side
  logic                  host_req_i;
  logic                  host_we_i;
  logic [ADDR_WIDTH-1:0] host_addr_i;
  logic [WORD_WIDTH-1:0] host_wdata_i;
  logic                  host_ack_o;
  logic [WORD_WIDTH-1:0] host_rdata_o;

  logic                  addr_err_o;
`ifdef TPU_BUF_WAIT_CNT_EN
  logic [WaitCntWidth-1:0] host_wait_o;
`endif

  // Responder (memory) side
  modport slave (
    input  en_i, we_i, addr_i, word_i,
    input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
    output word_o, host_ack_o, host_rdata_o, addr_err_o
`ifdef TPU_BUF_WAIT_CNT_EN
    , output host_wait_o
`endif
  );

  // Requester (TPU + host) side
  modport master (
    output en_i, we_i, addr_i, word_i,
    output host_req_i, host_we_i, host_addr_i, host_wdata_i,
    input  word_o, host_ack_o, host_rdata_o, addr_err_o
`ifdef TPU_BUF_WAIT_CNT_EN
    , input host_wait_o
`endif
  );

endinterface

// File: rtl/tpu_sp_ram.sv
// Single-port inferred RAM with a registered read port (1-cycle latency) and
// write-first behaviour. Contents are never reset.
module tpu_sp_ram
  import tpu_buf_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DefWordWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned AW         = ram_addr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic [WORD_WIDTH-1:0] rdata_o
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [WORD_WIDTH-1:0] rdata_q;

  // Array write and registered read; a write also forwards its data to the read port.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tpu_buffer_responder.sv
// Memory-side responder for one TPU operand/result buffer port. The TPU port
// gets 1-cycle reads and immediate writes; a host port shares the same RAM
// through a three-state FSM that only touches the RAM when the TPU is idle.
// Out-of-range addresses (>= DEPTH) drop writes, read as zero and set a sticky
// error flag. DEPTH must not exceed 2**ADDR_WIDTH.
// Optional: define TPU_BUF_WAIT_CNT_EN to add host_wait_o, a saturating count
// of cycles the current host request was blocked by the TPU.
module tpu_buffer_responder
  import tpu_buf_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DefWordWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = DefDepth
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  tpu_buffer_responder_if.slave        bus_io
);

  localparam int unsigned         RamAw    = ram_addr_width(DEPTH);
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

  host_state_e           state_q, state_d;
  logic                  h_we_q, h_we_d;
  logic [ADDR_WIDTH-1:0] h_addr_q, h_addr_d;
  logic [WORD_WIDTH-1:0] h_wdata_q, h_wdata_d;

  logic                  tpu_rd_q, tpu_rd_d;   // last edge was a TPU read
  logic                  rd_oor_q, rd_oor_d;   // last RAM read was out of range
  logic [WORD_WIDTH-1:0] word_q, word_d;       // held TPU read data
  logic [WORD_WIDTH-1:0] hrdata_q, hrdata_d;   // held host read data
  logic                  err_q, err_d;

  logic                  tpu_oor, host_oor, host_acc;
  logic                  ram_en, ram_we;
  logic [RamAw-1:0]      ram_addr;
  logic [WORD_WIDTH-1:0] ram_wdata, ram_rdata, rd_data;
  logic [WORD_WIDTH-1:0] word_out, hrdata_out;

  assign tpu_oor  = {1'b0, bus_io.addr_i} >= DepthLim;
  assign host_oor = {1'b0, h_addr_q} >= DepthLim;

`ifdef TPU_BUF_WAIT_CNT_EN
  logic [WaitCntWidth-1:0] wait_q, wait_d;
`endif

  // Host FSM: capture in HIdle, wait for a TPU-idle cycle in HPend, ack in HResp.
  always_comb begin
    state_d   = state_q;
    h_we_d    = h_we_q;
    h_addr_d  = h_addr_q;
    h_wdata_d = h_wdata_q;
    host_acc  = 1'b0;
`ifdef TPU_BUF_WAIT_CNT_EN
    wait_d    = wait_q;
`endif
    case (state_q)
      HIdle: begin
        if (bus_io.host_req_i) begin
          h_we_d    = bus_io.host_we_i;
          h_addr_d  = bus_io.host_addr_i;
          h_wdata_d = bus_io.host_wdata_i;
          state_d   = HPend;
`ifdef TPU_BUF_WAIT_CNT_EN
          wait_d    = '0;
`endif
        end
      end
      HPend: begin
        if (!bus_io.en_i) begin
          host_acc = 1'b1;
          state_d  = HResp;
        end else begin
`ifdef TPU_BUF_WAIT_CNT_EN
          if (wait_q != '1) begin
            wait_d = wait_q + 1'b1;
          end
`endif
        end
      end
      HResp:   state_d = HIdle;
      default: state_d = HIdle;
    endcase
  end

  // RAM port mux: the TPU always wins; the host only drives it on its access cycle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = bus_io.addr_i[RamAw-1:0];
    ram_wdata = bus_io.word_i;
    if (bus_io.en_i) begin
      ram_en = !tpu_oor;
      ram_we = bus_io.we_i;
    end else if (host_acc) begin
      ram_en    = !host_oor;
      ram_we    = h_we_q;
      ram_addr  = h_addr_q[RamAw-1:0];
      ram_wdata = h_wdata_q;
    end
  end

  // Read-path bookkeeping, output selection and the sticky error flag.
  always_comb begin
    tpu_rd_d   = bus_io.en_i & ~bus_io.we_i;
    rd_oor_d   = bus_io.en_i ? tpu_oor : host_oor;
    rd_data    = rd_oor_q ? '0 : ram_rdata;
    word_out   = tpu_rd_q ? rd_data : word_q;
    hrdata_out = ((state_q == HResp) && !h_we_q) ? rd_data : hrdata_q;
    word_d     = word_out;
    hrdata_d   = hrdata_out;
    err_d      = err_q | (bus_io.en_i & tpu_oor) | (host_acc & host_oor);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= HIdle;
      h_we_q    <= 1'b0;
      h_addr_q  <= '0;
      h_wdata_q <= '0;
      tpu_rd_q  <= 1'b0;
      rd_oor_q  <= 1'b0;
      word_q    <= '0;
      hrdata_q  <= '0;
      err_q     <= 1'b0;
`ifdef TPU_BUF_WAIT_CNT_EN
      wait_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      h_we_q    <= h_we_d;
      h_addr_q  <= h_addr_d;
      h_wdata_q <= h_wdata_d;
      tpu_rd_q  <= tpu_rd_d;
      rd_oor_q  <= rd_oor_d;
      word_q    <= word_d;
      hrdata_q  <= hrdata_d;
      err_q     <= err_d;
`ifdef TPU_BUF_WAIT_CNT_EN
      wait_q    <= wait_d;
`endif
    end
  end

  tpu_sp_ram #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (RamAw)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus_io.word_o       = word_out;
  assign bus_io.host_rdata_o = hrdata_out;
  assign bus_io.host_ack_o   = (state_q == HResp);
  assign bus_io.addr_err_o   = err_q;
`ifdef TPU_BUF_WAIT_CNT_EN
  assign bus_io.host_wait_o  = wait_q;
`endif

endmodule
